// File: rtl/cache_arb_pkg.sv
// Shared types for the I/D cache port arbiter: FSM state and requester identity.
package cache_arb_pkg;

  typedef enum logic {
    IDLE,
    SERVE
  } arb_state_t;

  typedef enum logic {
    PORT_I,
    PORT_D
  } port_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clear has priority over increment, both gated by en_i.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      if (clr_i) begin
        cnt_d = '0;
      end else if (inc_i && !(&cnt_q)) begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q_o = cnt_q;

endmodule

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one cache port between I-fetch and D requesters, with the miss
// owner locked until its fill completes, plus hit/miss statistics and a stuck-miss watchdog.
module cache_port_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned MAX_WAIT   = 64
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  en_i,
  input  logic                  i_req_i,
  input  logic [ADDR_WIDTH-1:0] i_addr_i,
  output logic                  i_done_o,
  output logic [DATA_WIDTH-1:0] i_rdata_o,
  input  logic                  d_req_i,
  input  logic                  d_write_en_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_data_i,
  output logic                  d_done_o,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic                  c_ready_o,
  output logic                  c_write_en_o,
  output logic [ADDR_WIDTH-1:0] c_addr_o,
  output logic [DATA_WIDTH-1:0] c_data_o,
  input  logic                  c_hit_i,
  input  logic [DATA_WIDTH-1:0] c_out_i,
  output logic [CNT_WIDTH-1:0]  hit_count_o,
  output logic [CNT_WIDTH-1:0]  miss_count_o,
  output logic                  timeout_o
);

  localparam int unsigned WaitWidth = $clog2(MAX_WAIT + 1);

  arb_state_t state_q, state_d;
  port_t      owner_q, owner_d;
  port_t      last_q, last_d;
  logic       timeout_q, timeout_d;

  port_t winner, sel;
  logic  active;
  logic  hit_inc, miss_inc, wait_inc, wait_clr;
  logic [WaitWidth-1:0] wait_cnt;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    timeout_d    = timeout_q;
    hit_inc      = 1'b0;
    miss_inc     = 1'b0;
    wait_inc     = 1'b0;
    wait_clr     = 1'b0;
    c_ready_o    = 1'b0;
    c_write_en_o = 1'b0;
    c_addr_o     = '0;
    c_data_o     = '0;
    i_done_o     = 1'b0;
    d_done_o     = 1'b0;
    i_rdata_o    = '0;
    d_rdata_o    = '0;

    // On a tie the side that was not served last wins.
    if (i_req_i && d_req_i) begin
      winner = (last_q == PORT_I) ? PORT_D : PORT_I;
    end else if (d_req_i) begin
      winner = PORT_D;
    end else begin
      winner = PORT_I;
    end

    sel    = (state_q == SERVE) ? owner_q : winner;
    active = en_i && !reset_i && ((state_q == SERVE) || i_req_i || d_req_i);

    if (active) begin
      c_ready_o = 1'b1;
      if (sel == PORT_D) begin
        c_write_en_o = d_write_en_i;
        c_addr_o     = d_addr_i;
        c_data_o     = d_data_i;
      end else begin
        c_addr_o = i_addr_i;
      end

      if (c_hit_i) begin
        if (sel == PORT_D) begin
          d_done_o  = 1'b1;
          d_rdata_o = c_out_i;
        end else begin
          i_done_o  = 1'b1;
          i_rdata_o = c_out_i;
        end
        last_d = sel;
        if (state_q == IDLE) begin
          hit_inc = 1'b1;
        end else begin
          wait_clr = 1'b1;
          state_d  = IDLE;
        end
      end else if (state_q == IDLE) begin
        owner_d  = sel;
        miss_inc = 1'b1;
        wait_inc = 1'b1;
        state_d  = SERVE;
      end else begin
        wait_inc = 1'b1;
        // Raised on the same edge the wait count reaches MAX_WAIT.
        if (wait_cnt >= WaitWidth'(MAX_WAIT - 1)) begin
          timeout_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      owner_q   <= PORT_I;
      last_q    <= PORT_I;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_hit_cnt (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .en_i   (en_i),
    .inc_i  (hit_inc),
    .clr_i  (1'b0),
    .q_o    (hit_count_o)
  );

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_miss_cnt (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .en_i   (en_i),
    .inc_i  (miss_inc),
    .clr_i  (1'b0),
    .q_o    (miss_count_o)
  );

  sat_counter #(
    .WIDTH(WaitWidth)
  ) u_wait_cnt (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .en_i   (en_i),
    .inc_i  (wait_inc),
    .clr_i  (wait_clr),
    .q_o    (wait_cnt)
  );

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Scoreboard bench for cache_port_arbiter: expected completions are queued as requests are
// driven and matched against i_done/d_done pulses; counters, muxing and timeout checked directly.
module tb_cache_port_arbiter;

  localparam logic [31:0] Key = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_done, d_done;
  logic [31:0] i_rdata, d_rdata;
  logic        c_ready, c_we, c_hit;
  logic [31:0] c_addr, c_data, c_out;
  logic [3:0]  hit_cnt, miss_cnt;
  logic        timeout;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    logic        side;  // 1 = D
    logic        chk;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Cache model: read data is a fixed function of the presented address.
  assign c_out = c_addr ^ Key;

  cache_port_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .CNT_WIDTH (4),
    .MAX_WAIT  (8)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .en_i        (en),
    .i_req_i     (i_req),
    .i_addr_i    (i_addr),
    .i_done_o    (i_done),
    .i_rdata_o   (i_rdata),
    .d_req_i     (d_req),
    .d_write_en_i(d_we),
    .d_addr_i    (d_addr),
    .d_data_i    (d_wdata),
    .d_done_o    (d_done),
    .d_rdata_o   (d_rdata),
    .c_ready_o   (c_ready),
    .c_write_en_o(c_we),
    .c_addr_o    (c_addr),
    .c_data_o    (c_data),
    .c_hit_i     (c_hit),
    .c_out_i     (c_out),
    .hit_count_o (hit_cnt),
    .miss_count_o(miss_cnt),
    .timeout_o   (timeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic side, input logic chk, input logic [31:0] data);
    exp_t e;
    e.side = side;
    e.chk  = chk;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && (i_done || d_done)) begin
      exp_t e;
      check_eq("done_exclusive", 32'(i_done && d_done), 32'd0);
      if (sb.size() == 0) begin
        check_eq("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("done_side", 32'(d_done), 32'(e.side));
        if (e.chk) check_eq("rdata", d_done ? d_rdata : i_rdata, e.data);
        check_eq("idle_rdata_zero", d_done ? i_rdata : d_rdata, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; en = 1'b1; i_req = 1'b1; d_req = 1'b0; d_we = 1'b0;
    i_addr = 32'h100; d_addr = '0; d_wdata = '0; c_hit = 1'b1;

    // Reset: outputs quiet even with a request and hit present.
    @(negedge clk);
    check_eq("rst_c_ready", 32'(c_ready), 32'd0);
    check_eq("rst_i_done", 32'(i_done), 32'd0);
    check_eq("rst_c_addr", c_addr, 32'd0);
    check_eq("rst_hits", 32'(hit_cnt), 32'd0);
    check_eq("rst_misses", 32'(miss_cnt), 32'd0);
    check_eq("rst_timeout", 32'(timeout), 32'd0);
    cyc();
    reset = 1'b0; i_req = 1'b0; c_hit = 1'b0;

    // 1: I-only hit completes same cycle.
    cyc();
    i_req = 1'b1; i_addr = 32'h100; c_hit = 1'b1;
    push_exp(1'b0, 1'b1, 32'h100 ^ Key);
    @(negedge clk);
    check_eq("t1_c_addr", c_addr, 32'h100);
    check_eq("t1_c_we", 32'(c_we), 32'd0);
    check_eq("t1_i_done", 32'(i_done), 32'd1);
    cyc();
    i_req = 1'b0; c_hit = 1'b0;
    @(negedge clk);
    check_eq("t1_hits", 32'(hit_cnt), 32'd1);
    check_eq("t1_idle_ready", 32'(c_ready), 32'd0);

    // 2: simultaneous hits, D wins the tie, I follows.
    cyc();
    i_req = 1'b1; i_addr = 32'h104; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; c_hit = 1'b1;
    push_exp(1'b1, 1'b1, 32'h300 ^ Key);
    push_exp(1'b0, 1'b1, 32'h104 ^ Key);
    @(negedge clk);
    check_eq("t2_c_addr_d", c_addr, 32'h300);
    cyc();
    d_req = 1'b0;
    @(negedge clk);
    check_eq("t2_c_addr_i", c_addr, 32'h104);
    cyc();
    i_req = 1'b0; c_hit = 1'b0;
    @(negedge clk);
    check_eq("t2_hits", 32'(hit_cnt), 32'd3);

    // 3: D write miss, owner locked for 6 cycles while I waits.
    cyc();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
    i_req = 1'b1; i_addr = 32'h108; c_hit = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      if (n == 6) begin
        c_hit = 1'b1;
        push_exp(1'b1, 1'b0, 32'd0);
      end
      @(negedge clk);
      check_eq("t3_c_addr", c_addr, 32'h200);
      check_eq("t3_c_we", 32'(c_we), 32'd1);
      check_eq("t3_c_data", c_data, 32'hDEAD_BEEF);
      if (n < 6) cyc();
    end
    cyc();
    d_req = 1'b0; d_we = 1'b0;
    push_exp(1'b0, 1'b1, 32'h108 ^ Key);
    @(negedge clk);
    check_eq("t3_c_addr_i", c_addr, 32'h108);
    check_eq("t3_misses", 32'(miss_cnt), 32'd1);
    cyc();
    i_req = 1'b0; c_hit = 1'b0;
    @(negedge clk);
    check_eq("t3_hits", 32'(hit_cnt), 32'd4);

    // 5: en=0 freeze in SERVE; wait count must not advance, so timeout lands on schedule.
    cyc();
    d_req = 1'b1; d_addr = 32'h400; c_hit = 1'b0;
    cyc(); cyc(); cyc();
    en = 1'b0; c_hit = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("t5_frozen_ready", 32'(c_ready), 32'd0);
      check_eq("t5_frozen_done", 32'(d_done), 32'd0);
      cyc();
    end
    en = 1'b1; c_hit = 1'b0;
    for (int e = 7; e <= 11; e++) begin
      cyc();
      @(negedge clk);
      check_eq("t5_timeout", 32'(timeout), 32'(e >= 11));
    end
    cyc();
    c_hit = 1'b1;
    push_exp(1'b1, 1'b1, 32'h400 ^ Key);
    @(negedge clk);
    check_eq("t5_c_addr", c_addr, 32'h400);
    cyc();
    d_req = 1'b0; c_hit = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_eq("t4_timeout_sticky", 32'(timeout), 32'd1);
    end
    check_eq("t5_misses", 32'(miss_cnt), 32'd2);

    // 6: reset during SERVE, then saturate both counters.
    cyc();
    i_req = 1'b1; i_addr = 32'h500; c_hit = 1'b0;
    cyc();
    reset = 1'b1;
    @(negedge clk);
    check_eq("t6_rst_ready", 32'(c_ready), 32'd0);
    check_eq("t6_rst_addr", c_addr, 32'd0);
    check_eq("t6_rst_hits", 32'(hit_cnt), 32'd0);
    check_eq("t6_rst_misses", 32'(miss_cnt), 32'd0);
    check_eq("t6_rst_timeout", 32'(timeout), 32'd0);
    cyc();
    reset = 1'b0; i_req = 1'b0;
    cyc();
    i_req = 1'b1; c_hit = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      i_addr = 32'h600 + 32'(4 * k);
      push_exp(1'b0, 1'b1, (32'h600 + 32'(4 * k)) ^ Key);
      @(negedge clk);
      if (k > 0) check_eq("t6_hit_sat", 32'(hit_cnt), (k > 15) ? 32'd15 : 32'(k));
      cyc();
    end
    for (int k = 0; k < 16; k++) begin
      i_addr = 32'h800 + 32'(4 * k);
      c_hit = 1'b0;
      cyc();
      c_hit = 1'b1;
      push_exp(1'b0, 1'b1, (32'h800 + 32'(4 * k)) ^ Key);
      cyc();
    end
    i_req = 1'b0; c_hit = 1'b0;
    @(negedge clk);
    check_eq("t6_miss_sat", 32'(miss_cnt), 32'd15);
    check_eq("t6_hit_hold", 32'(hit_cnt), 32'd15);
    check_eq("t6_timeout_clear", 32'(timeout), 32'd0);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
